bp_be_redirect_ctl: RTL
=======================

BP_BE_REDIRECT_CTL -- requirements
Module: bp_be_redirect_ctl

Interface
REQ-001 Parameter: vaddr_width_p, 39, virtual address width of branch targets.
REQ-002 Parameter: drain_cycles_p, 3, post-redirect pipeline drain cycles, legal range 0..15.
REQ-003 Parameter: cnt_width_p, 32, width of performance counters.
REQ-004 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n_i  input  1  asynchronous, active-low reset.
REQ-006 br_v_i  input  1  control-pipe resolution packet valid, already flush-qualified.
REQ-007 br_branch_i  input  1  resolving instruction is a branch or jump.
REQ-008 br_btaken_i  input  1  resolved taken.
REQ-009 br_npc_i  input  vaddr_width_p  resolved next PC.
REQ-010 pred_npc_i  input  vaddr_width_p  predicted next PC of the same instruction.
REQ-011 fe_redirect_v_o  output  1  redirect request to frontend.
REQ-012 fe_redirect_ready_i  input  1  frontend accepts redirect.
REQ-013 fe_redirect_npc_o  output  vaddr_width_p  redirect target, bit 0 always 0.
REQ-014 fe_redirect_taken_o  output  1  redirect caused by taken branch.
REQ-015 flush_o  output  1  kill younger in-flight instructions, incl. control-pipe flush.
REQ-016 dispatch_stall_o  output  1  block dispatch.
REQ-017 idle_o  output  1  FSM in IDLE.

Function
REQ-018 The block SHALL implement FSM states IDLE, REDIRECT and DRAIN.
REQ-019 In IDLE, mispredict SHALL be br_v_i & (br_npc_i != pred_npc_i), compared over all vaddr_width_p bits.
REQ-020 On mispredict in IDLE, the block SHALL capture br_npc_i (bit 0 cleared) and br_btaken_i & br_branch_i, then enter REDIRECT next cycle.
REQ-021 In REDIRECT, fe_redirect_v_o SHALL be 1 and npc/taken SHALL stay stable until fe_redirect_ready_i is sampled 1.
REQ-022 A REDIRECT handshake SHALL go to DRAIN with counter = drain_cycles_p-1, or to IDLE if drain_cycles_p is 0.
REQ-023 In DRAIN, the counter SHALL decrement each cycle, and the FSM SHALL return to IDLE in the cycle after it reads 0.
REQ-024 flush_o and dispatch_stall_o SHALL be 1 exactly in REDIRECT and DRAIN; fe_redirect_v_o SHALL be 0 outside REDIRECT.
REQ-025 br_v_i SHALL be ignored outside IDLE, so the oldest mispredict wins and younger ones are dropped.
REQ-026 A mispredict in the first IDLE cycle after DRAIN SHALL be accepted normally.
REQ-027 Ready asserted in the first REDIRECT cycle SHALL complete the handshake in that cycle, giving minimum detect-to-handshake latency of 1 cycle.
REQ-028 When fe_redirect_v_o is 0, fe_redirect_npc_o SHALL hold its last captured value.

Reset
REQ-029 Asserting reset_n_i low SHALL asynchronously force IDLE and clear captured npc, taken and drain counter, from any state including mid-handshake, dropping any pending redirect.
REQ-030 Reset values SHALL be: fe_redirect_v_o=0, fe_redirect_npc_o=0, fe_redirect_taken_o=0, flush_o=0, dispatch_stall_o=0, idle_o=1, counters=0.
REQ-031 Deassertion SHALL be used synchronously; the first edge after deassertion evaluates inputs in IDLE.

Configuration
REQ-032 With BP_BE_REDIRECT_PERF_EN defined, the block SHALL add outputs branch_cnt_o and mispredict_cnt_o (cnt_width_p each).
REQ-033 branch_cnt_o SHALL increment on br_v_i & br_branch_i in IDLE, and mispredict_cnt_o SHALL increment on each accepted mispredict; both wrap modulo 2^cnt_width_p.
REQ-034 Without BP_BE_REDIRECT_PERF_EN, the counter ports and logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-035 The FSM state enum (bp_be_redirect_state_e) and the redirect packet struct (npc, taken) SHALL be defined in bp_be_pkg.
REQ-036 The drain counter SHALL be a single sub-module instance, bp_be_redirect_drain_counter; all other logic is flat.

Verification
REQ-037 Match: br_v_i=1, br_npc=pred=0x1000 -> flush_o stays 0, idle_o stays 1, no redirect.
REQ-038 Mispredict, ready tied 1, drain_cycles_p=3: br_npc=0x2001, pred=0x1004, taken branch -> next cycle fe_redirect_v_o=1 with npc=0x2000, taken=1 for 1 cycle; flush_o=1 for 4 cycles; then idle_o=1.
REQ-039 Backpressure: ready=0 for 5 cycles, then 1 -> npc constant for 6 valid cycles, single handshake.
REQ-040 Second mispredict (npc=0x3000) during REDIRECT -> ignored; only 0x2000 is issued.
REQ-041 reset_n_i pulsed low mid-REDIRECT -> fe_redirect_v_o and flush_o drop asynchronously to 0, idle_o=1.
REQ-042 With BP_BE_REDIRECT_PERF_EN, counters preloaded to 2^32-1 plus one mispredicting branch -> both counters read 0.

Source files
------------

// File: rtl/bp_be_pkg.sv
// Shared types for the backend redirect controller.
// Optional perf counters are enabled with BP_BE_REDIRECT_PERF_EN.
package bp_be_pkg;

    localparam int vaddr_max_width_gp = 64;
    localparam int drain_cnt_width_gp = 4;

    typedef enum logic [1:0] {
        e_idle,
        e_redirect,
        e_drain
    } bp_be_redirect_state_e;

    typedef struct packed {
        logic [vaddr_max_width_gp-1:0] npc;
        logic                          taken;
    } bp_be_redirect_pkt_s;

endpackage

// File: rtl/bp_be_redirect_drain_counter.sv
// Down-counter timing the post-redirect pipeline drain window.
module bp_be_redirect_drain_counter
    import bp_be_pkg::*;
#(
    parameter int width_p = drain_cnt_width_gp
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               load_i,
    input  logic [width_p-1:0] load_val_i,
    input  logic               dec_i,
    output logic [width_p-1:0] cnt_o,
    output logic               zero_o
);

    logic [width_p-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bp_be_redirect_ctl.sv
// Backend mispredict detection and frontend redirect/flush control.
// Optional perf counters are enabled with BP_BE_REDIRECT_PERF_EN.
module bp_be_redirect_ctl
    import bp_be_pkg::*;
#(
    parameter int vaddr_width_p  = 39,
    parameter int drain_cycles_p = 3,
    parameter int cnt_width_p    = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     br_v_i,
    input  logic                     br_branch_i,
    input  logic                     br_btaken_i,
    input  logic [vaddr_width_p-1:0] br_npc_i,
    input  logic [vaddr_width_p-1:0] pred_npc_i,
    output logic                     fe_redirect_v_o,
    input  logic                     fe_redirect_ready_i,
    output logic [vaddr_width_p-1:0] fe_redirect_npc_o,
    output logic                     fe_redirect_taken_o,
    output logic                     flush_o,
    output logic                     dispatch_stall_o,
`ifdef BP_BE_REDIRECT_PERF_EN
    output logic [cnt_width_p-1:0]   branch_cnt_o,
    output logic [cnt_width_p-1:0]   mispredict_cnt_o,
`endif
    output logic                     idle_o
);

    localparam int dw_lp = drain_cnt_width_gp;
    localparam logic [dw_lp-1:0] drain_init_lp =
        (drain_cycles_p == 0) ? '0 : dw_lp'(drain_cycles_p - 1);

    bp_be_redirect_state_e state_q, state_n;
    bp_be_redirect_pkt_s   pkt_q, pkt_n;

    logic             mispredict;
    logic             capture;
    logic             drain_load;
    logic             drain_dec;
    logic             drain_zero;
    logic [dw_lp-1:0] drain_cnt;

    assign mispredict = br_v_i & (br_npc_i != pred_npc_i);

    always_comb begin
        state_n    = state_q;
        capture    = 1'b0;
        drain_load = 1'b0;
        drain_dec  = 1'b0;
        unique case (state_q)
            e_idle: begin
                if (mispredict) begin
                    capture = 1'b1;
                    state_n = e_redirect;
                end
            end
            e_redirect: begin
                if (fe_redirect_ready_i) begin
                    if (drain_cycles_p == 0) begin
                        state_n = e_idle;
                    end else begin
                        drain_load = 1'b1;
                        state_n    = e_drain;
                    end
                end
            end
            e_drain: begin
                if (drain_zero) state_n = e_idle;
                else            drain_dec = 1'b1;
            end
            default: state_n = e_idle;
        endcase
    end

    always_comb begin
        pkt_n = pkt_q;
        if (capture) begin
            pkt_n.npc                     = '0;
            pkt_n.npc[vaddr_width_p-1:0]  = br_npc_i;
            pkt_n.npc[0]                  = 1'b0;
            pkt_n.taken                   = br_btaken_i & br_branch_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_idle;
            pkt_q   <= '0;
        end else begin
            state_q <= state_n;
            pkt_q   <= pkt_n;
        end
    end

    bp_be_redirect_drain_counter #(
        .width_p(dw_lp)
    ) drain_counter (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .load_i    (drain_load),
        .load_val_i(drain_init_lp),
        .dec_i     (drain_dec),
        .cnt_o     (drain_cnt),
        .zero_o    (drain_zero)
    );

    // Upper struct bits only exist to fit the widest supported address.
    logic unused_npc_hi;
    logic [dw_lp-1:0] unused_drain_cnt;
    assign unused_npc_hi    = ^pkt_q.npc;
    assign unused_drain_cnt = drain_cnt;

    assign fe_redirect_v_o     = (state_q == e_redirect);
    assign fe_redirect_npc_o   = pkt_q.npc[vaddr_width_p-1:0];
    assign fe_redirect_taken_o = fe_redirect_v_o & pkt_q.taken;
    assign flush_o             = (state_q != e_idle);
    assign dispatch_stall_o    = (state_q != e_idle);
    assign idle_o              = (state_q == e_idle);

`ifdef BP_BE_REDIRECT_PERF_EN
    logic [cnt_width_p-1:0] branch_cnt_q;
    logic [cnt_width_p-1:0] mispredict_cnt_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (idle_o && br_v_i && br_branch_i)
                branch_cnt_q <= branch_cnt_q + 1'b1;
            if (capture)
                mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
        end
    end

    assign branch_cnt_o     = branch_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;
`else
    localparam int unused_cnt_width_lp = cnt_width_p;
`endif

endmodule
